// File: rtl/fifo_flags.sv
// Flagged FIFO with block-RAM storage and registered full/empty/almost-full/count.
// Read data appears 1 or 2 cycles after an accepted read, with a matching valid strobe.
module fifo_flags #(
  parameter int LOGQ  = 32,
  parameter int LOGN  = 8,
  parameter int DELAY = 1,
  parameter int AFULL = (1 << LOGN) - 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_wr,
  input  logic [LOGQ-1:0] fifo_din,
  input  logic            fifo_rd,
  output logic [LOGQ-1:0] fifo_dout,
  output logic            fifo_vld,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic            fifo_afull,
  output logic [LOGN:0]   fifo_count,
  input  logic            err_clr,
  output logic            fifo_ovf,
  output logic            fifo_udf
);

  localparam logic [LOGN:0] AFULL_TH = (LOGN+1)'(AFULL);

  logic [LOGQ-1:0] r_mem [2**LOGN];
  logic [LOGN:0]   r_ptrWr, r_ptrRd, r_count;
  logic            r_full, r_empty, r_afull;
  logic            r_ovf, r_udf;
  logic [LOGQ-1:0] r_rdData;
  logic            r_rdVld;

  logic            w_wa, w_ra;
  logic [LOGN:0]   w_ptrWrNext, w_ptrRdNext, w_countNext;
  logic            w_fullNext, w_emptyNext;

  assign w_wa = fifo_wr & ~r_full;
  assign w_ra = fifo_rd & ~r_empty;

  always_comb begin
    w_ptrWrNext = r_ptrWr + {{LOGN{1'b0}}, w_wa};
    w_ptrRdNext = r_ptrRd + {{LOGN{1'b0}}, w_ra};
    w_countNext = r_count;
    case ({w_wa, w_ra})
      2'b10:   w_countNext = r_count + (LOGN+1)'(1);
      2'b01:   w_countNext = r_count - (LOGN+1)'(1);
      default: w_countNext = r_count;
    endcase
    // Same address with differing wrap bits means the writer is a full lap ahead.
    w_fullNext  = (w_ptrWrNext[LOGN-1:0] == w_ptrRdNext[LOGN-1:0]) &&
                  (w_ptrWrNext[LOGN] != w_ptrRdNext[LOGN]);
    w_emptyNext = (w_ptrWrNext == w_ptrRdNext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptrWr <= '0;
      r_ptrRd <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_afull <= 1'b0;
    end else begin
      r_ptrWr <= w_ptrWrNext;
      r_ptrRd <= w_ptrRdNext;
      r_count <= w_countNext;
      r_full  <= w_fullNext;
      r_empty <= w_emptyNext;
      r_afull <= (w_countNext >= AFULL_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wa)
      r_mem[r_ptrWr[LOGN-1:0]] <= fifo_din;
  end

  // Nonblocking RAM access returns old contents on a same-address read and write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdData <= '0;
      r_rdVld  <= 1'b0;
    end else begin
      r_rdVld <= w_ra;
      if (w_ra)
        r_rdData <= r_mem[r_ptrRd[LOGN-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (fifo_wr & r_full)  | (r_ovf & ~err_clr);
      r_udf <= (fifo_rd & r_empty) | (r_udf & ~err_clr);
    end
  end

  generate
    if (DELAY == 2) begin : g_outReg
      logic [LOGQ-1:0] r_outData;
      logic            r_outVld;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_outData <= '0;
          r_outVld  <= 1'b0;
        end else begin
          r_outVld <= r_rdVld;
          if (r_rdVld)
            r_outData <= r_rdData;
        end
      end

      assign fifo_dout = r_outData;
      assign fifo_vld  = r_outVld;
    end else begin : g_direct
      assign fifo_dout = r_rdData;
      assign fifo_vld  = r_rdVld;
    end
  endgenerate

  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign fifo_afull = r_afull;
  assign fifo_count = r_count;
  assign fifo_ovf   = r_ovf;
  assign fifo_udf   = r_udf;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: one DELAY=1 and one DELAY=2 instance share stimulus
// (LOGQ=8, LOGN=2, AFULL=3); expected values are hand-computed constants.
module tb_fifo_flags;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr, rd, errClr;
  logic [7:0] din;

  logic [7:0] dout1, dout2;
  logic       vld1, full1, empty1, afull1, ovf1, udf1;
  logic       vld2, full2, empty2, afull2, ovf2, udf2;
  logic [2:0] count1, count2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fifo_flags #(.LOGQ(8), .LOGN(2), .DELAY(1), .AFULL(3)) dut1 (
    .clk(clock), .rst(reset), .fifo_wr(wr), .fifo_din(din), .fifo_rd(rd),
    .fifo_dout(dout1), .fifo_vld(vld1), .fifo_full(full1), .fifo_empty(empty1),
    .fifo_afull(afull1), .fifo_count(count1), .err_clr(errClr),
    .fifo_ovf(ovf1), .fifo_udf(udf1)
  );

  fifo_flags #(.LOGQ(8), .LOGN(2), .DELAY(2), .AFULL(3)) dut2 (
    .clk(clock), .rst(reset), .fifo_wr(wr), .fifo_din(din), .fifo_rd(rd),
    .fifo_dout(dout2), .fifo_vld(vld2), .fifo_full(full2), .fifo_empty(empty2),
    .fifo_afull(afull2), .fifo_count(count2), .err_clr(errClr),
    .fifo_ovf(ovf2), .fifo_udf(udf2)
  );

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr     = w;
    din    = d;
    rd     = r;
    errClr = c;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] wVals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       expAfull [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       expFull  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       expVld2  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] expDout2 [6] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA3};

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    checkOutput("rst_empty1", empty1, 1);
    checkOutput("rst_full1",  full1,  0);
    checkOutput("rst_afull1", afull1, 0);
    checkOutput("rst_count1", count1, 0);
    checkOutput("rst_vld1",   vld1,   0);
    checkOutput("rst_dout1",  dout1,  0);
    checkOutput("rst_ovf1",   ovf1,   0);
    checkOutput("rst_udf1",   udf1,   0);
    checkOutput("rst_empty2", empty2, 1);
    checkOutput("rst_full2",  full2,  0);
    checkOutput("rst_afull2", afull2, 0);
    checkOutput("rst_count2", count2, 0);
    checkOutput("rst_vld2",   vld2,   0);
    checkOutput("rst_dout2",  dout2,  0);
    checkOutput("rst_ovf2",   ovf2,   0);
    checkOutput("rst_udf2",   udf2,   0);
    @(negedge clock);
    reset = 1'b0;

    // Fill to capacity, watching count and flags after every write.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, wVals[i], 1'b0, 1'b0);
      tick();
      checkOutput("fill_count", count1, i + 1);
      checkOutput("fill_empty", empty1, 0);
      checkOutput("fill_afull", afull1, expAfull[i]);
      checkOutput("fill_full",  full1,  expFull[i]);
    end

    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_flag",  ovf1,   1);
    checkOutput("ovf_count", count1, 4);
    checkOutput("ovf_full",  full1,  1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("drain_vld",  vld1,  1);
      checkOutput("drain_dout", dout1, wVals[i]);
    end
    checkOutput("drain_empty", empty1, 1);
    checkOutput("drain_count", count1, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("idle_vld",  vld1,  0);
    checkOutput("idle_dout", dout1, 8'h44);

    // Underflow and sticky-clear behaviour.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("udf_flag",  udf1,   1);
    checkOutput("udf_vld",   vld1,   0);
    checkOutput("udf_dout",  dout1,  8'h44);
    checkOutput("udf_count", count1, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("clr_udf", udf1, 0);
    checkOutput("clr_ovf", ovf1, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("clr_vs_set_udf", udf1, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("clr_again_udf", udf1, 0);

    // Steady state at count=2 with simultaneous read and write across two pointer wraps.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    tick();
    checkOutput("stream_pre_count", count1, 2);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(k + 2), 1'b1, 1'b0);
      tick();
      checkOutput("stream_count", count1, 2);
      checkOutput("stream_vld",   vld1,   1);
      checkOutput("stream_dout",  dout1,  k);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("tail_dout0", dout1, 8'h0A);
    tick();
    checkOutput("tail_dout1", dout1, 8'h0B);
    checkOutput("tail_empty", empty1, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Two-cycle latency instance with back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'b0, 8'h00, (t < 4), 1'b0);
      tick();
      checkOutput("d2_vld", vld2, expVld2[t]);
      if (t > 0) checkOutput("d2_dout", dout2, expDout2[t]);
      if (t < 4) checkOutput("d1_dout", dout1, 8'hA0 + 8'(t));
    end

    // Asynchronous reset while reads are in flight.
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("pre_rst_vld1", vld1, 1);
    #2;
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("arst_vld1",   vld1,   0);
    checkOutput("arst_dout1",  dout1,  0);
    checkOutput("arst_empty1", empty1, 1);
    checkOutput("arst_count1", count1, 0);
    checkOutput("arst_vld2",   vld2,   0);
    checkOutput("arst_dout2",  dout2,  0);
    tick();
    tick();
    @(negedge clock);
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      checkOutput("post_rst_vld1", vld1, 0);
      checkOutput("post_rst_vld2", vld2, 0);
    end
    checkOutput("post_rst_empty1", empty1, 1);
    checkOutput("post_rst_empty2", empty2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
